branch_sequencer: RTL and testbench

//  Program-counter and branch sequencer for the 8-bit core. Steps PC, drives the

---
 rtl/cpu_pkg.sv | 18 +
 rtl/branch_cond_eval.sv | 25 ++
 rtl/branch_sequencer.sv | 141 ++++++++++++++
 tb/tb_branch_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit core's sequencer: FSM states and branch conditions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BR_EVAL = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    BR_EQ     = 2'd0,
    BR_NE     = 2'd1,
    BR_LT     = 2'd2,
    BR_ALWAYS = 2'd3
  } br_cond_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: decides taken from (cond, a, b).
module branch_cond_eval
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  br_cond_t          cond_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              taken_o
);

  // LT is an unsigned compare
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      BR_EQ:     taken_o = (a_i == b_i);
      BR_NE:     taken_o = (a_i != b_i);
      BR_LT:     taken_o = (a_i < b_i);
      BR_ALWAYS: taken_o = 1'b1;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// PC / branch sequencer: steps PC, captures conditional branches, resolves them
// in a fixed second cycle and owns run/halt/done control.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int DATA_W = 8,
  parameter int OFF_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              IsBranch,
  input  logic              BrUseR0,
  input  logic [1:0]        BrCond,
  input  logic [OFF_W-1:0]  BrOffset,
  input  logic [DATA_W-1:0] BrOpA,
  input  logic [DATA_W-1:0] BrOpB,
  output logic [PC_W-1:0]   PC,
  output logic              InstrEn,
  output logic              Branch,
  output logic              Taken,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  TakenCount
);

  seq_state_t        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              branch_q, branch_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  br_cond_t          cond_q, cond_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              br_taken_s;
  logic              instr_en_s;
  logic [PC_W-1:0]   off_sext_s;

  assign off_sext_s = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .cond_i  (cond_q),
    .a_i     (BrOpA),
    .b_i     (BrOpB),
    .taken_o (br_taken_s)
  );

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    branch_d   = branch_q;
    taken_d    = 1'b0;
    cnt_d      = cnt_q;
    cond_d     = cond_q;
    off_d      = off_q;
    instr_en_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (!Stall) begin
          instr_en_s = 1'b1;
          if (Halt) begin
            state_d = DONE;
          end else if (IsBranch) begin
            cond_d   = br_cond_t'(BrCond);
            off_d    = BrOffset;
            branch_d = BrUseR0;
            state_d  = BR_EVAL;
          end else begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = state_q;
        end
      end
      BR_EVAL: begin
        // Operand mux select was registered last edge, so BrOpA is valid here
        if (!Stall) begin
          if (br_taken_s) begin
            pc_d    = pc_q + off_sext_s;
            taken_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      pc_q     <= {PC_W{1'b0}};
      branch_q <= 1'b0;
      taken_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      cond_q   <= BR_EQ;
      off_q    <= {OFF_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      branch_q <= branch_d;
      taken_q  <= taken_d;
      cnt_q    <= cnt_d;
      cond_q   <= cond_d;
      off_q    <= off_d;
    end
  end

  assign PC         = pc_q;
  assign InstrEn    = instr_en_s;
  assign Branch     = branch_q;
  assign Taken      = taken_q;
  assign Busy       = (state_q == RUN) || (state_q == BR_EVAL);
  assign Done       = (state_q == DONE);
  assign TakenCount = cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_branch_sequencer;

  logic        CLK;
  logic        ResetN;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Stall;
  logic        Halt;
  logic        IsBranch;
  logic        BrUseR0;
  logic [1:0]  BrCond;
  logic [5:0]  BrOffset;
  logic [7:0]  BrOpA;
  logic [7:0]  BrOpB;
  logic [9:0]  PC;
  logic        InstrEn;
  logic        Branch;
  logic        Taken;
  logic        Busy;
  logic        Done;
  logic [15:0] TakenCount;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: program is active (running or resolving a branch),
  // a branch is pending resolution, or the program has finished.
  bit m_active, m_pending, m_done, m_branch, m_taken;
  int m_pc, m_cnt, m_cond, m_off;

  branch_sequencer dut (
    .CLK(CLK), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .IsBranch(IsBranch), .BrUseR0(BrUseR0),
    .BrCond(BrCond), .BrOffset(BrOffset), .BrOpA(BrOpA), .BrOpB(BrOpB),
    .PC(PC), .InstrEn(InstrEn), .Branch(Branch), .Taken(Taken),
    .Busy(Busy), .Done(Done), .TakenCount(TakenCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pending = 0; m_done = 0; m_branch = 0; m_taken = 0;
    m_pc = 0; m_cnt = 0; m_cond = 0; m_off = 0;
  endtask

  function automatic bit cond_holds(int c, int a, int b);
    case (c)
      0: return a == b;
      1: return a != b;
      2: return a < b;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step();
    m_taken = 0;
    if (!m_active) begin
      if (Start) begin
        m_pc = StartAddr; m_cnt = 0; m_active = 1; m_done = 0;
      end
    end else if (Stall) begin
      // frozen
    end else if (m_pending) begin
      if (cond_holds(m_cond, BrOpA, BrOpB)) begin
        m_pc = ((m_pc + m_off) % 1024 + 1024) % 1024;
        m_taken = 1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
      m_pending = 0;
    end else if (Halt) begin
      m_active = 0; m_done = 1;
    end else if (IsBranch) begin
      m_pending = 1;
      m_cond = BrCond;
      m_off = (BrOffset >= 6'd32) ? int'(BrOffset) - 64 : int'(BrOffset);
      m_branch = BrUseR0;
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
  endtask

  task automatic check_regs();
    chk("PC", PC, m_pc);
    chk("Branch", Branch, m_branch);
    chk("Taken", Taken, m_taken);
    chk("Done", Done, m_done);
    chk("Busy", Busy, m_active);
    chk("TakenCount", TakenCount, m_cnt);
  endtask

  task automatic clear_in();
    Start = 0; StartAddr = 10'h000; Stall = 0; Halt = 0; IsBranch = 0;
    BrUseR0 = 0; BrCond = 2'd0; BrOffset = 6'd0; BrOpA = 8'h00; BrOpB = 8'h00;
  endtask

  // One clock: check combinational outputs before the edge, registered after.
  task automatic cycle();
    #1;
    chk("InstrEn", InstrEn, m_active && !m_pending && !Stall);
    chk("BusyPre", Busy, m_active);
    @(posedge CLK);
    model_step();
    #1;
    check_regs();
    @(negedge CLK);
  endtask

  task automatic async_reset();
    ResetN = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("InstrEnRst", InstrEn, 1'b0);
    @(negedge CLK);
    ResetN = 1'b1;
  endtask

  task automatic run_from(input logic [9:0] addr);
    clear_in(); Halt = 1; cycle();
    clear_in(); Start = 1; StartAddr = addr; cycle();
    clear_in();
  endtask

  initial begin
    clear_in();
    model_reset();
    ResetN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_regs();
    chk("InstrEnRst", InstrEn, 1'b0);
    ResetN = 1'b1;

    // Start at 0x010 and issue three plain instructions
    Start = 1; StartAddr = 10'h010; cycle();
    chk("start_pc", PC, 10'h010);
    clear_in();
    for (int i = 0; i < 3; i++) cycle();
    chk("seq_pc", PC, 10'h013);

    // Start during RUN is ignored
    Start = 1; StartAddr = 10'h200; cycle();
    chk("start_ignored", PC, 10'h014);

    // Taken EQ branch, offset -4, R0 operand
    run_from(10'h020);
    IsBranch = 1; BrUseR0 = 1; BrCond = 2'd0; BrOffset = 6'h3C;
    BrOpA = 8'h5A; BrOpB = 8'h5A; cycle();
    chk("br_sel", Branch, 1'b1);
    chk("br_capture_pc", PC, 10'h020);
    IsBranch = 0; cycle();
    chk("eq_taken_pc", PC, 10'h01C);
    chk("eq_taken_pulse", Taken, 1'b1);
    chk("eq_taken_cnt", TakenCount, 16'd1);
    clear_in(); cycle();
    chk("taken_pulse_end", Taken, 1'b0);

    // Not-taken NE branch
    run_from(10'h040);
    IsBranch = 1; BrCond = 2'd1; BrOffset = 6'h05; BrOpA = 8'h33; BrOpB = 8'h33;
    cycle(); IsBranch = 0; cycle();
    chk("ne_pc", PC, 10'h041);
    chk("ne_taken", Taken, 1'b0);

    // ALWAYS branch wraps past the top of the address space
    run_from(10'h3FF);
    IsBranch = 1; BrCond = 2'd3; BrOffset = 6'h02; cycle(); IsBranch = 0; cycle();
    chk("wrap_pc", PC, 10'h001);

    // Negative offset wrapping below zero
    run_from(10'h000);
    IsBranch = 1; BrCond = 2'd3; BrOffset = 6'h3F; cycle(); IsBranch = 0; cycle();
    chk("wrap_neg_pc", PC, 10'h3FF);

    // Halt beats IsBranch
    run_from(10'h100);
    Halt = 1; IsBranch = 1; BrCond = 2'd3; cycle();
    chk("halt_done", Done, 1'b1);
    chk("halt_pc", PC, 10'h100);
    clear_in(); cycle();

    // Stall three cycles in BR_EVAL, then reset mid-branch
    run_from(10'h080);
    IsBranch = 1; BrUseR0 = 1; BrCond = 2'd3; BrOffset = 6'h08; cycle();
    clear_in(); Stall = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_pc", PC, 10'h080);
    async_reset();
    chk("rst_busy", Busy, 1'b0);
    clear_in(); cycle();

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      clear_in();
      if ($urandom_range(99) == 0) begin
        async_reset();
      end else begin
        Start     = ($urandom_range(7) == 0);
        StartAddr = 10'($urandom);
        Stall     = ($urandom_range(4) == 0);
        Halt      = ($urandom_range(15) == 0);
        IsBranch  = ($urandom_range(2) == 0);
        BrUseR0   = 1'($urandom);
        BrCond    = 2'($urandom);
        BrOffset  = 6'($urandom);
        BrOpA     = 8'($urandom);
        BrOpB     = ($urandom_range(1) == 0) ? BrOpA : 8'($urandom);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
